// File: rtl/divider_seq_if.sv
// divider_seq_if: request/response handshake bundle for divider_seq.
//   Request side : i_valid/o_ready, i_signed, i_dividend, i_divisor
//   Response side: o_valid/i_ready, o_quotient, o_remainder, o_divByZero, o_overflow
//   slave  modport -> the divider; master modport -> the requester/consumer.
interface divider_seq_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic             i_signed;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_divByZero;
    logic             o_overflow;

    modport slave (
        input  i_valid, i_signed, i_dividend, i_divisor, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder, o_divByZero, o_overflow
    );

    modport master (
        output i_valid, i_signed, i_dividend, i_divisor, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, o_divByZero, o_overflow
    );
endinterface

// File: rtl/divider_seq.sv
// divider_seq: iterative restoring integer divider, signed or unsigned per op.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_cg    : clock-gate enable; 0 freezes FSM, counter and datapath
//   bus     : divider_seq_if.slave (request and result handshakes)
// Latency is fixed at WIDTH/BITS_PER_CYCLE + 1 edges from accept to o_valid,
// including divide-by-zero and signed MIN/-1 overflow.
module divider_seq #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_cg,
    divider_seq_if.slave   bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % BITS_PER_CYCLE != 0) || (WIDTH < 2)) begin : g_bad_params
        $error("divider_seq: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    // Operation context captured on accept
    logic               neg_quo;       // operand signs differ
    logic               neg_rem;       // dividend was negative
    logic               div_by_zero;
    logic               overflow;
    logic [WIDTH-1:0]   orig_dvd;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;

    // Registered results
    logic [WIDTH-1:0]   q_out, r_out;
    logic               dbz_out, ovf_out;

    assign bus.o_ready     = (state == IDLE) || ((state == DONE) && bus.i_ready);
    assign bus.o_valid     = (state == DONE);
    assign bus.o_quotient  = q_out;
    assign bus.o_remainder = r_out;
    assign bus.o_divByZero = dbz_out;
    assign bus.o_overflow  = ovf_out;

    assign accept = bus.i_valid && bus.o_ready && i_cg;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  state <= IDLE;
        else if (i_cg) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.i_ready) state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- operand conditioning ----------------
    logic             in_dvd_neg, in_dvs_neg;
    logic [WIDTH-1:0] in_dvd_mag, in_dvs_mag;

    assign in_dvd_neg = bus.i_signed && bus.i_dividend[WIDTH-1];
    assign in_dvs_neg = bus.i_signed && bus.i_divisor[WIDTH-1];
    // |MIN| wraps to MIN, which is still the right unsigned magnitude
    assign in_dvd_mag = in_dvd_neg ? -bus.i_dividend : bus.i_dividend;
    assign in_dvs_mag = in_dvs_neg ? -bus.i_divisor  : bus.i_divisor;

    // ---------------- restoring step(s) ----------------
    // {rem, quo} shifts left one bit per step; the dividend magnitude drains
    // out of quo's MSB into rem while quotient bits fill quo's LSB.
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;            // WIDTH+1-bit difference plus borrow

    always_comb begin
        step_rem = rem_r;
        step_quo = quo_r;
        shifted  = '0;
        diff     = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            shifted  = {step_rem, step_quo[WIDTH-1]};
            diff     = {1'b0, shifted} - {2'b00, dvs_mag};
            step_quo = {step_quo[WIDTH-2:0], ~diff[WIDTH+1]};
            // remainder stays below the divisor, so WIDTH bits suffice
            step_rem = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    // ---------------- result magnitudes ----------------
    logic [WIDTH-1:0] q_mag, r_mag;

    if (ABSTRACT_MODEL != 0) begin : g_abstract
        logic [WIDTH-1:0] dvd_abs;
        assign dvd_abs = neg_rem ? -orig_dvd : orig_dvd;
        assign q_mag   = (dvs_mag == '0) ? '1      : dvd_abs / dvs_mag;
        assign r_mag   = (dvs_mag == '0) ? dvd_abs : dvd_abs % dvs_mag;
    end else begin : g_iterative
        assign q_mag = quo_r;
        assign r_mag = rem_r;
    end

    // ---------------- sign fix and corner cases ----------------
    logic [WIDTH-1:0] fix_q, fix_r;

    always_comb begin
        fix_q = neg_quo ? -q_mag : q_mag;
        fix_r = neg_rem ? -r_mag : r_mag;
        if (div_by_zero) begin
            fix_q = '1;
            fix_r = orig_dvd;
        end else if (overflow) begin
            fix_q = {1'b1, {(WIDTH-1){1'b0}}};
            fix_r = '0;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            orig_dvd    <= '0;
            dvs_mag     <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            q_out       <= '0;
            r_out       <= '0;
            dbz_out     <= 1'b0;
            ovf_out     <= 1'b0;
        end else if (i_cg) begin
            if (accept) begin
                cnt         <= CNT_W'(N - 1);
                neg_quo     <= in_dvd_neg ^ in_dvs_neg;
                neg_rem     <= in_dvd_neg;
                div_by_zero <= (bus.i_divisor == '0);
                overflow    <= bus.i_signed
                               && (bus.i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                               && (bus.i_divisor == '1);
                orig_dvd    <= bus.i_dividend;
                dvs_mag     <= in_dvs_mag;
                rem_r       <= '0;
                quo_r       <= in_dvd_mag;
            end else if (state == CALC) begin
                cnt   <= cnt - 1'b1;
                rem_r <= step_rem;
                quo_r <= step_quo;
            end
            if (state == FIX) begin
                q_out   <= fix_q;
                r_out   <= fix_r;
                dbz_out <= div_by_zero;
                ovf_out <= overflow;
            end
        end
    end

`ifndef SYNTHESIS
    a_valid_not_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.o_valid |-> !(state inside {CALC, FIX}));
    a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (bus.o_valid && !bus.i_ready) |=>
            ($stable(q_out) && $stable(r_out) && $stable(dbz_out) && $stable(ovf_out)
             && bus.o_valid));
    a_flags_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(dbz_out && ovf_out));
`endif
endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cg = 1'b1;
    always #5 clk = ~clk;

    divider_seq_if #(.WIDTH(8))  if8  ();
    divider_seq_if #(.WIDTH(8))  ifa  ();
    divider_seq_if #(.WIDTH(16)) if16 ();

    divider_seq #(.WIDTH(8),  .BITS_PER_CYCLE(1), .ABSTRACT_MODEL(0)) u8   (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .bus(if8));
    divider_seq #(.WIDTH(8),  .BITS_PER_CYCLE(1), .ABSTRACT_MODEL(1)) ua   (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .bus(ifa));
    divider_seq #(.WIDTH(16), .BITS_PER_CYCLE(4), .ABSTRACT_MODEL(0)) u16  (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .bus(if16));

    // abstract instance shadows the 8-bit iterative one
    assign ifa.i_valid    = if8.i_valid;
    assign ifa.i_signed   = if8.i_signed;
    assign ifa.i_dividend = if8.i_dividend;
    assign ifa.i_divisor  = if8.i_divisor;
    assign ifa.i_ready    = if8.i_ready;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on integers, truncating division
    task automatic ref_div(input int w, input bit sgn, input longint a, input longint b,
                           output longint q, output longint r, output bit dz, output bit ov);
        longint mask, minv, sa, sb;
        mask = (longint'(1) << w) - 1;
        minv = longint'(1) << (w - 1);
        dz = (b == 0);
        ov = sgn && (a == minv) && (b == mask);
        if (dz) begin
            q = mask; r = a;
        end else if (ov) begin
            q = minv; r = 0;
        end else if (sgn) begin
            sa = (a >= minv) ? a - (mask + 1) : a;
            sb = (b >= minv) ? b - (mask + 1) : b;
            q = (sa / sb) & mask;
            r = (sa % sb) & mask;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    task automatic wait8(output int n, input int stall_at, input int stall_len);
        n = 0;
        while (!if8.o_valid && n < 40) begin
            if (n == stall_at) cg = 1'b0;
            if (n == stall_at + stall_len) cg = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        cg = 1'b1;
    endtask

    task automatic op8(input string tag, input bit sgn, input logic [7:0] a, input logic [7:0] b,
                       input int stall_at, input int stall_len);
        longint eq, er; bit edz, eov; int n;
        ref_div(8, sgn, a, b, eq, er, edz, eov);
        if8.i_signed = sgn; if8.i_dividend = a; if8.i_divisor = b; if8.i_valid = 1'b1;
        @(posedge clk); #1;
        if8.i_valid = 1'b0;
        wait8(n, stall_at, stall_len);
        chk({tag, "_lat"}, n, 9 + stall_len);
        chk({tag, "_q"},   if8.o_quotient, eq);
        chk({tag, "_r"},   if8.o_remainder, er);
        chk({tag, "_dz"},  if8.o_divByZero, edz);
        chk({tag, "_ov"},  if8.o_overflow, eov);
        chk({tag, "_aq"},  ifa.o_quotient, eq);
        chk({tag, "_ar"},  ifa.o_remainder, er);
        chk({tag, "_av"},  ifa.o_valid, 1);
        if8.i_ready = 1'b1;
        @(posedge clk); #1;
        if8.i_ready = 1'b0;
        chk({tag, "_vdrop"}, if8.o_valid, 0);
    endtask

    task automatic op16(input string tag, input bit sgn, input logic [15:0] a, input logic [15:0] b);
        longint eq, er; bit edz, eov; int n;
        ref_div(16, sgn, a, b, eq, er, edz, eov);
        if16.i_signed = sgn; if16.i_dividend = a; if16.i_divisor = b; if16.i_valid = 1'b1;
        @(posedge clk); #1;
        if16.i_valid = 1'b0;
        n = 0;
        while (!if16.o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_q"},   if16.o_quotient, eq);
        chk({tag, "_r"},   if16.o_remainder, er);
        chk({tag, "_dz"},  if16.o_divByZero, edz);
        chk({tag, "_ov"},  if16.o_overflow, eov);
        if16.i_ready = 1'b1;
        @(posedge clk); #1;
        if16.i_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] a8, b8;
        logic [15:0] a16, b16;
        if8.i_valid = 0; if8.i_signed = 0; if8.i_dividend = 0; if8.i_divisor = 0; if8.i_ready = 0;
        if16.i_valid = 0; if16.i_signed = 0; if16.i_dividend = 0; if16.i_divisor = 0; if16.i_ready = 0;

        #2;
        chk("rst_valid", if8.o_valid, 0);
        chk("rst_ready", if8.o_ready, 1);
        chk("rst_q",     if8.o_quotient, 0);
        chk("rst_r",     if8.o_remainder, 0);
        chk("rst_flags", {if8.o_divByZero, if8.o_overflow}, 0);
        chk("rst16_rdy", if16.o_ready, 1);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // directed
        op8("u100d7", 0, 8'd100, 8'd7, -1, 0);
        chk("u100d7_spec_q", if8.o_quotient, 8'h0E);
        op8("sm7d2",  1, 8'hF9, 8'h02, -1, 0);
        op8("s7dm2",  1, 8'h07, 8'hFE, -1, 0);
        op8("udz",    0, 8'h55, 8'h00, -1, 0);
        op8("sdz",    1, 8'h85, 8'h00, -1, 0);
        op8("sovf",   1, 8'h80, 8'hFF, -1, 0);
        op8("umax",   0, 8'hFF, 8'h01, -1, 0);
        op8("smin2",  1, 8'h80, 8'h02, -1, 0);
        op16("w16",   0, 16'hFFFF, 16'h0003);
        op16("w16s",  1, 16'h8000, 16'hFFFF);

        // random
        for (int i = 0; i < 40; i++) begin
            a8 = 8'($urandom);
            b8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            op8("rnd8", 1'($urandom_range(0, 1)), a8, b8, -1, 0);
        end
        for (int i = 0; i < 20; i++) begin
            a16 = 16'($urandom);
            b16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 300));
            op16("rnd16", 1'($urandom_range(0, 1)), a16, b16);
        end

        // backpressure then same-edge handshake + accept
        if8.i_signed = 0; if8.i_dividend = 8'd50; if8.i_divisor = 8'd6; if8.i_valid = 1'b1;
        @(posedge clk); #1;
        if8.i_valid = 1'b0;
        wait8(n, -1, 0);
        chk("bp_lat", n, 9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", if8.o_valid, 1);
            chk("bp_ready", if8.o_ready, 0);
            chk("bp_q", if8.o_quotient, 8);
            chk("bp_r", if8.o_remainder, 2);
        end
        if8.i_dividend = 8'd200; if8.i_divisor = 8'd10; if8.i_valid = 1'b1; if8.i_ready = 1'b1;
        #1;
        chk("b2b_ready", if8.o_ready, 1);
        @(posedge clk); #1;
        if8.i_valid = 1'b0; if8.i_ready = 1'b0;
        chk("b2b_busy", if8.o_valid, 0);
        wait8(n, -1, 0);
        chk("b2b_lat", n, 9);
        chk("b2b_q", if8.o_quotient, 20);
        chk("b2b_r", if8.o_remainder, 0);

        // reset mid-CALC while the previous result is still held
        if8.i_ready = 1'b1;
        if8.i_dividend = 8'd77; if8.i_divisor = 8'd5; if8.i_valid = 1'b1;
        @(posedge clk); #1;
        if8.i_valid = 1'b0; if8.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        chk("mrst_valid", if8.o_valid, 0);
        chk("mrst_ready", if8.o_ready, 1);
        chk("mrst_q",     if8.o_quotient, 0);
        chk("mrst_r",     if8.o_remainder, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_novalid", if8.o_valid, 0);
        op8("post_rst", 0, 8'd9, 8'd3, -1, 0);

        // clock-gate stall of 4 cycles mid-CALC
        op8("cg_stall", 0, 8'd100, 8'd7, 3, 4);
        op8("cg_stall_s", 1, 8'hF9, 8'h02, 5, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Parametrised iterative integer divider with valid/ready handshakes on both sides. It supports signed or unsigned operation, selected per operation, and retires BITS_PER_CYCLE quotient bits per cycle. Divide-by-zero and signed-overflow are flagged, with fixed results. It is intended as the shared divide unit behind small CPU and DSP datapaths, and replaces the single-pulse, busy-polled divider.

Parameters:
WIDTH, 8, operand/result width in bits; minimum 2.
BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; WIDTH % BITS_PER_CYCLE == 0 is checked by an elaboration assertion.
ABSTRACT_MODEL, 0, if set, results come from behavioural / and % with identical handshake timing and corner-case results.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  asynchronous active-low reset.
i_cg  in  1  clock-gate enable; when 0, all state holds.
i_valid  in  1  operation request.
o_ready  out  1  divider can accept a request this cycle.
i_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
i_dividend  in  WIDTH  dividend; sampled on accept.
i_divisor  in  WIDTH  divisor; sampled on accept.
o_valid  out  1  result valid.
i_ready  in  1  consumer takes the result.
o_quotient  out  WIDTH  quotient.
o_remainder  out  WIDTH  remainder.
o_divByZero  out  1  divisor was 0; valid with o_valid.
o_overflow  out  1  signed MIN / -1; valid with o_valid.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_valid=0, o_ready=1; o_quotient, o_remainder, o_divByZero, o_overflow = 0.
- Accept condition: i_valid && o_ready && i_cg at a rising edge.
- o_ready = (state==IDLE) || (state==DONE && i_ready). This allows back-to-back operation with no bubble on the input side.
- Definitions: N = WIDTH/BITS_PER_CYCLE. E0 is the edge at which a request is accepted.
- IDLE: on accept, move to CALC. Latch sign flags, absolute operand magnitudes (signed mode), the flags divByZero=(divisor==0) and overflow=(signed && dividend==MIN && divisor==all-ones), and step counter = N-1.
- CALC: each cycle, perform BITS_PER_CYCLE restoring shift/subtract steps on a {remainder, quotient} register of 2*WIDTH bits. The subtract is WIDTH+1 bits wide; the borrow bit selects whether to restore. The counter decrements each cycle; in the cycle with counter==0, move to FIX. CALC occupies edges E1..EN.
- FIX (one cycle, edge EN+1): apply sign correction and corner cases, register the outputs, move to DONE.
  - Signed mode: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Divide-by-zero: quotient = all-ones, remainder = original dividend, in both modes.
  - Overflow: quotient = MIN (1 followed by zeros), remainder = 0.
  - Division by zero and overflow take the same latency as a normal operation. Total latency is fixed at N+1 edges after E0.
- DONE: o_valid=1. Outputs and flags are held stable until o_valid && i_ready.
  - On handshake with no new accept: go to IDLE, o_valid drops next cycle.
  - On handshake with a simultaneous accept: go straight to CALC with the new operands.
- i_valid in CALC/FIX is ignored (o_ready=0). Requesters must hold i_valid until accepted.
- i_cg=0: the FSM, counter and datapath freeze. o_ready/o_valid are still driven from current state, but no transfer is counted.
- Reset mid-operation: the operation is abandoned, the block returns to IDLE with reset output values, and no result is produced.
- Quotient/remainder magnitudes never exceed WIDTH bits; the MIN/-1 case is the only unrepresentable one and is handled as overflow.
- Assertions:
  - o_valid implies !(state in CALC/FIX).
  - Outputs stable while o_valid && !i_ready.
  - o_divByZero and o_overflow are never both 1.

Test Plan:
1. WIDTH=8, BPC=1, unsigned 100/7 -> accepted at E0; o_valid at E9; q=14 (0x0E), r=2; flags 0.
2. Signed -7/2 (0xF9/0x02) -> q=0xFD (-3), r=0xFF (-1). Signed 7/-2 -> q=0xFD, r=0x01. Latency 9 edges.
3. Corner cases: unsigned 0x55/0 -> q=0xFF, r=0x55, o_divByZero=1. Signed 0x80/0xFF -> q=0x80, r=0x00, o_overflow=1. Both with latency 9.
4. Backpressure and back-to-back: hold i_ready=0 for 5 cycles after o_valid -> outputs and o_valid stable, o_ready=0. Then assert i_ready with i_valid high carrying 200/10 -> same-edge handshake plus accept; next result q=20, r=0 at +9 edges.
5. Parameter sweep: WIDTH=16, BPC=4, unsigned 0xFFFF/0x0003 -> q=0x5555, r=0, o_valid 5 edges after accept. Random signed/unsigned vectors compared against the ABSTRACT_MODEL=1 instance.
6. Reset in CALC: assert i_rst_n=0 at E3 -> immediately o_valid=0, o_ready=1, outputs 0. After release, 9/3 -> q=3, r=0. Toggling i_cg=0 for 4 cycles mid-CALC extends latency by exactly 4.
